regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (rd addr/data/wren) among NREQ writeback requesters
//  (ALU, load unit, CSR, mul/div). Arbitration is round-robin with a valid/ready handshake per requester.
//  The grant is registered into one output stage that drives the regfile write port directly.
//  Hit outputs flag reads that target the in-flight write, so the read path can forward it.
// PARAMETERS
//  NREQ  4   number of writeback requesters (2..8)
//  DW    32  data width
//  AW    5   register address width (x0..x31)
// PORTS
//  i_clk          in   1         clock, rising edge
//  i_reset        in   1         synchronous, active-high reset
//  i_hold         in   1         1 = grant nothing this cycle
//  i_req_valid    in   NREQ      requester n has a write pending
//  o_req_ready    out  NREQ      one-hot grant, combinational; transfer = valid & ready
//  i_req_addr     in   NREQ*AW   rd address, requester n at [n*AW +: AW]
//  i_req_data     in   NREQ*DW   rd data, requester n at [n*DW +: DW]
//  o_rd_addr      out  AW        to regfile i_rd_addr
//  o_rd_data      out  DW        to regfile i_rd_data
//  o_rd_wren      out  1         to regfile i_rd_wren
//  i_rs1_addr     in   AW        read address, source 1
//  i_rs2_addr     in   AW        read address, source 2
//  o_rs1_hit      out  1         o_rd_wren & (o_rd_addr == i_rs1_addr), combinational
//  o_rs2_hit      out  1         same for rs2; forward data is o_rd_data
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is synchronous and active-high.
//  - Reset values: o_rd_wren=0, o_rd_addr=0, o_rd_data=0, rr_ptr=0.
//  - While i_reset=1: o_req_ready=0, regardless of i_req_valid.
//  - Arbitration:
//    - Each cycle, scan requesters from rr_ptr upward, mod NREQ.
//    - The first one with i_req_valid=1 is the grant g; o_req_ready has exactly bit g set.
//    - If i_hold=1 or no valid requester: o_req_ready=0.
//    - Ready never depends on o_rd_wren. The output stage cannot stall; one grant per cycle at most.
//  - Accept (valid & ready on g) at edge k:
//    - o_rd_addr <= addr[g] and o_rd_data <= data[g].
//    - o_rd_wren <= (addr[g] != 0).
//    - rr_ptr <= (g == NREQ-1) ? 0 : g+1.
//  - No accept at edge k: o_rd_wren <= 0. o_rd_addr, o_rd_data and rr_ptr hold.
//  - Latency: the request is visible on the write port exactly 1 cycle after the accept.
//    The regfile commits it at the following edge.
//  - x0 writes: the handshake completes (ready=1) and rr_ptr advances, but o_rd_wren stays 0. No hit for x0.
//  - Requester contract: a requester holds valid/addr/data stable until ready. Dropping valid early is legal.
//    The arbiter keeps no per-requester state.
//  - Simultaneous valids: only g transfers; the others wait. Starvation bound is NREQ-1 cycles with i_hold=0.
//  - Hit: o_rsX_hit=1 only when o_rd_wren=1 and the addresses match, so rsX=0 never hits.
//    Both rs1 and rs2 may hit at once.
//  - Reset mid-operation: a pending output write is discarded (wren=0 next cycle). The round-robin pointer returns to 0.
// TESTING
//  T1 Reset: i_reset=1 for 2 cycles, all valid=1.
//     -> ready=0 and wren=0 throughout.
//     -> First cycle after release: ready=4'b0001.
//  T2 Round-robin: all 4 valid, addr n+1, data 0x100+n, held for 5 cycles.
//     -> ready sequence 0001,0010,0100,1000,0001.
//     -> Next cycles: wren=1 with addr 1,2,3,4,1.
//  T3 Single requester: only req2 valid, addr 7, data 0xDEADBEEF.
//     -> ready=0100 in the same cycle.
//     -> Next cycle: wren=1, addr=7, data=0xDEADBEEF.
//     -> rr_ptr=3, so a following req3/req0 tie grants req3.
//  T4 x0 and hold: req1 writes addr 0.
//     -> ready=0010; next cycle wren=0; rr_ptr=2.
//     Then i_hold=1 with all valid.
//     -> ready=0 and wren=0 next cycle; rr_ptr unchanged.
//  T5 Hit: output stage holds addr 5, data 0x12345678; rs1=5, rs2=0.
//     -> rs1_hit=1, rs2_hit=0.
//     Repeat with rs1=rs2=5.
//     -> both hits=1.
//  T6 Reset mid-op: assert i_reset while wren=1.
//     -> Next cycle: wren=0, addr=0, data=0.
//     -> After release: the first grant is req0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter feeding the single register-file write port.
// One registered output stage; hit flags let the read path forward it.
module regfile_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_hold,
    input  logic [NREQ-1:0]    i_req_valid,
    output logic [NREQ-1:0]    o_req_ready,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*DW-1:0] i_req_data,
    output logic [AW-1:0]      o_rd_addr,
    output logic [DW-1:0]      o_rd_data,
    output logic               o_rd_wren,
    input  logic [AW-1:0]      i_rs1_addr,
    input  logic [AW-1:0]      i_rs2_addr,
    output logic               o_rs1_hit,
    output logic               o_rs2_hit
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   rr_ptr_d;
    logic [AW-1:0]   rd_addr_q;
    logic [AW-1:0]   rd_addr_d;
    logic [DW-1:0]   rd_data_q;
    logic [DW-1:0]   rd_data_d;
    logic            rd_wren_q;
    logic            rd_wren_d;

    logic [PW:0]     scan_idx;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_found;
    logic [NREQ-1:0] gnt_oh;
    logic            accept;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_data;

    // Scan requesters starting at the round-robin pointer, wrapping mod NREQ
    always_comb begin
        scan_idx  = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (scan_idx >= (PW+1)'(NREQ)) begin
                scan_idx = scan_idx - (PW+1)'(NREQ);
            end
            if (!gnt_found && i_req_valid[scan_idx[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[PW-1:0];
            end
        end
    end

    // Pick the winner's address and data out of the flat request buses
    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (PW'(n) == gnt_idx) begin
                gnt_addr = i_req_addr[n*AW +: AW];
                gnt_data = i_req_data[n*DW +: DW];
            end
        end
    end

    // One-hot ready; suppressed by reset and hold, never by the output stage
    always_comb begin
        gnt_oh = '0;
        if (!i_reset && !i_hold && gnt_found) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    assign o_req_ready = gnt_oh;
    assign accept      = |(gnt_oh & i_req_valid);

    // Next output stage and pointer; x0 completes the handshake but never writes
    always_comb begin
        rd_wren_d = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            rd_addr_d = gnt_addr;
            rd_data_d = gnt_data;
            rd_wren_d = |gnt_addr;
            rr_ptr_d  = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Output stage and pointer registers; reset drops any pending write
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_wren_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            rd_wren_q <= rd_wren_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign o_rd_addr = rd_addr_q;
    assign o_rd_data = rd_data_q;
    assign o_rd_wren = rd_wren_q;

    assign o_rs1_hit = rd_wren_q && (rd_addr_q == i_rs1_addr);
    assign o_rs2_hit = rd_wren_q && (rd_addr_q == i_rs2_addr);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table plus hand sequences,
// with output-stage expectations queued at grant time and popped after the edge.
module tb_regfile_wb_arbiter;

    typedef struct {
        logic            rst;
        logic            hold;
        logic [3:0]      valid;
        logic [3:0][4:0] addr;
        logic [3:0][31:0] data;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [3:0]      ready;
    } vec_t;

    typedef struct {
        logic        wren;
        logic [4:0]  addr;
        logic [31:0] data;
    } out_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_hold;
    logic [3:0]  i_req_valid;
    logic [3:0]  o_req_ready;
    logic [19:0] i_req_addr;
    logic [127:0] i_req_data;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_wren;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic        o_rs1_hit;
    logic        o_rs2_hit;

    int n_chk  = 0;
    int n_fail = 0;

    out_t        sbq[$];
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(4), .DW(32), .AW(5)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_hold      (i_hold),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_addr  (i_req_addr),
        .i_req_data  (i_req_data),
        .o_rd_addr   (o_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_rd_wren   (o_rd_wren),
        .i_rs1_addr  (i_rs1_addr),
        .i_rs2_addr  (i_rs2_addr),
        .o_rs1_hit   (o_rs1_hit),
        .o_rs2_hit   (o_rs2_hit)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic hold,
                                input logic [3:0] valid,
                                input logic [3:0][4:0] addr,
                                input logic [3:0][31:0] data,
                                input logic [4:0] rs1,
                                input logic [4:0] rs2,
                                input logic [3:0] ready);
        vec_t v;
        v.rst   = rst;
        v.hold  = hold;
        v.valid = valid;
        v.addr  = addr;
        v.data  = data;
        v.rs1   = rs1;
        v.rs2   = rs2;
        v.ready = ready;
        return v;
    endfunction

    // Drive one cycle: check ready before the edge, output stage after it
    task automatic step(input vec_t v);
        out_t e;
        out_t got;
        int   g;
        i_reset     = v.rst;
        i_hold      = v.hold;
        i_req_valid = v.valid;
        i_req_addr  = v.addr;
        i_req_data  = v.data;
        i_rs1_addr  = v.rs1;
        i_rs2_addr  = v.rs2;
        @(negedge clk);
        chk("ready", 32'(o_req_ready), 32'(v.ready));
        if (v.rst) begin
            e.wren = 1'b0;
            e.addr = '0;
            e.data = '0;
        end else if (v.ready != 4'b0) begin
            g = 0;
            for (int n = 0; n < 4; n++) begin
                if (v.ready[n]) g = n;
            end
            e.addr = v.addr[g];
            e.data = v.data[g];
            e.wren = (v.addr[g] != 5'd0);
        end else begin
            e.wren = 1'b0;
            e.addr = last_addr;
            e.data = last_data;
        end
        last_addr = e.addr;
        last_data = e.data;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sbq.pop_front();
            chk("wren", 32'(o_rd_wren), 32'(got.wren));
            chk("addr", 32'(o_rd_addr), 32'(got.addr));
            chk("data", o_rd_data, got.data);
            chk("rs1_hit", 32'(o_rs1_hit),
                32'(got.wren && got.addr == v.rs1));
            chk("rs2_hit", 32'(o_rs2_hit),
                32'(got.wren && got.addr == v.rs2));
        end
    endtask

    vec_t tbl[$];

    initial begin
        logic [3:0][4:0]  A;
        logic [3:0][31:0] D;
        logic [3:0][4:0]  A3;
        logic [3:0][31:0] D3;
        logic [3:0][4:0]  A4;
        logic [3:0][4:0]  A5;
        logic [3:0][31:0] D5;
        logic [3:0][4:0]  A6;
        logic [3:0][31:0] D6;

        A = {5'd4, 5'd3, 5'd2, 5'd1};
        D = {32'h103, 32'h102, 32'h101, 32'h100};
        A3 = A;  A3[2] = 5'd7;  D3 = D;  D3[2] = 32'hDEADBEEF;
        A4 = A;  A4[1] = 5'd0;
        A5 = A;  A5[0] = 5'd5;  D5 = D;  D5[0] = 32'h12345678;
        A6 = A;  A6[1] = 5'd9;  D6 = D;  D6[1] = 32'h00000ABC;

        // reset held with all valid
        tbl.push_back(mk(1, 0, 4'b1111, A, D, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 0, 4'b1111, A, D, 0, 0, 4'b0000));
        // round robin across all four
        tbl.push_back(mk(0, 0, 4'b1111, A, D, 0, 0, 4'b0001));
        tbl.push_back(mk(0, 0, 4'b1111, A, D, 0, 0, 4'b0010));
        tbl.push_back(mk(0, 0, 4'b1111, A, D, 3, 0, 4'b0100));
        tbl.push_back(mk(0, 0, 4'b1111, A, D, 0, 4, 4'b1000));
        tbl.push_back(mk(0, 0, 4'b1111, A, D, 1, 1, 4'b0001));
        // single requester, then req3/req0 tie
        tbl.push_back(mk(0, 0, 4'b0100, A3, D3, 7, 0, 4'b0100));
        tbl.push_back(mk(0, 0, 4'b1001, A, D, 0, 0, 4'b1000));
        // x0 write, hold, pointer preserved, idle
        tbl.push_back(mk(0, 0, 4'b0010, A4, D, 0, 0, 4'b0010));
        tbl.push_back(mk(0, 1, 4'b1111, A, D, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 4'b1111, A, D, 0, 0, 4'b0100));
        tbl.push_back(mk(0, 0, 4'b0000, A, D, 3, 3, 4'b0000));

        foreach (tbl[i]) step(tbl[i]);

        // forwarding hits on the in-flight write
        step(mk(0, 0, 4'b0001, A5, D5, 5, 0, 4'b0001));
        i_rs2_addr = 5'd5;
        #1;
        chk("both_hit1", 32'(o_rs1_hit), 32'd1);
        chk("both_hit2", 32'(o_rs2_hit), 32'd1);
        i_rs1_addr = 5'd0;
        i_rs2_addr = 5'd4;
        #1;
        chk("miss_hit1", 32'(o_rs1_hit), 32'd0);
        chk("miss_hit2", 32'(o_rs2_hit), 32'd0);

        // reset while a write is pending
        step(mk(0, 0, 4'b0010, A6, D6, 9, 0, 4'b0010));
        step(mk(1, 0, 4'b1111, A, D, 0, 0, 4'b0000));
        step(mk(0, 0, 4'b1111, A, D, 1, 0, 4'b0001));

        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
